// File: rtl/blinky_binary_poller.sv
// Periodic PIO poller: reads a narrow input field through a simple read master,
// debounces it and reports changes of the debounced value via STATUS and irq.
module blinky_binary_poller #(
   parameter int DATA_W         = 2,
   parameter int DEFAULT_PERIOD = 50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  s_address,
   input  logic        s_read,
   input  logic        s_write,
   input  logic [31:0] s_writedata,
   output logic [31:0] s_readdata,
   output logic [1:0]  m_address,
   output logic        m_read,
   input  logic        m_waitrequest,
   input  logic [31:0] m_readdata,
   output logic        irq
);

   localparam logic [23:0] RESET_PERIOD = 24'(DEFAULT_PERIOD);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT,
      ST_REQ,
      ST_CAPT,
      ST_EVAL
   } state_t;

   state_t state;
   state_t state_nxt;

   logic              ctrl_en;
   logic              ctrl_irq_en;
   logic [23:0]       period;
   logic [3:0]        debounce;
   logic [DATA_W-1:0] stable;
   logic [DATA_W-1:0] sample;
   logic [DATA_W-1:0] prev_sample;
   logic              chg;
   logic [3:0]        match_cnt;
   logic [3:0]        match_nxt;
   logic [23:0]       counter;
   logic [23:0]       reload_val;
   logic [3:0]        deb_eff;
   logic              reload;
   logic              chg_set;
   logic              chg_clr;
   logic [31:0]       rd_mux;
   logic              unused_bits;

   // PERIOD and DEBOUNCE of zero behave as one.
   assign reload_val = (period == 24'd0) ? 24'd0 : period - 24'd1;
   assign deb_eff    = (debounce == 4'd0) ? 4'd1 : debounce;

   assign m_read    = (state == ST_REQ);
   assign m_address = 2'b00;

   assign chg_clr     = s_write && (s_address == 2'd2) && s_writedata[8];
   assign unused_bits = ^{s_writedata[31:24], m_readdata[31:DATA_W]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      reload    = 1'b0;
      case (state)
         ST_IDLE: begin
            if (ctrl_en) begin
               state_nxt = ST_WAIT;
               reload    = 1'b1;
            end
         end
         ST_WAIT: begin
            if (!ctrl_en) begin
               state_nxt = ST_IDLE;
            end else if (counter == 24'd0) begin
               state_nxt = ST_REQ;
            end
         end
         // An accepted-or-pending request always completes, even if EN drops.
         ST_REQ: begin
            if (!m_waitrequest) begin
               state_nxt = ST_CAPT;
            end
         end
         ST_CAPT: begin
            state_nxt = ST_EVAL;
         end
         ST_EVAL: begin
            reload    = 1'b1;
            state_nxt = ctrl_en ? ST_WAIT : ST_IDLE;
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         counter <= 24'd0;
      end else if (reload) begin
         counter <= reload_val;
      end else if ((state == ST_WAIT) && (counter != 24'd0)) begin
         counter <= counter - 24'd1;
      end
   end

   always_comb begin
      match_nxt = match_cnt;
      chg_set   = 1'b0;
      if (state == ST_EVAL) begin
         if (sample == prev_sample) begin
            match_nxt = (match_cnt == 4'd15) ? 4'd15 : match_cnt + 4'd1;
         end else begin
            match_nxt = 4'd1;
         end
         chg_set = (match_nxt >= deb_eff) && (sample != stable);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sample      <= '0;
         prev_sample <= '0;
         match_cnt   <= 4'd0;
         stable      <= '0;
      end else begin
         if (state == ST_CAPT) begin
            sample <= m_readdata[DATA_W-1:0];
         end
         if (state == ST_EVAL) begin
            prev_sample <= sample;
         end
         match_cnt <= match_nxt;
         if (chg_set) begin
            stable <= sample;
         end
      end
   end

   // A change detected in the same cycle as a software clear must not be lost.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         chg <= 1'b0;
      end else begin
         chg <= chg_set | (chg & ~chg_clr);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ctrl_en     <= 1'b0;
         ctrl_irq_en <= 1'b0;
         period      <= RESET_PERIOD;
         debounce    <= 4'd1;
      end else if (s_write) begin
         case (s_address)
            2'd0: begin
               ctrl_en     <= s_writedata[0];
               ctrl_irq_en <= s_writedata[1];
            end
            2'd1: begin
               period <= s_writedata[23:0];
            end
            2'd3: begin
               debounce <= s_writedata[3:0];
            end
            default: begin
            end
         endcase
      end
   end

   always_comb begin
      rd_mux = '0;
      case (s_address)
         2'd0: begin
            rd_mux[1:0] = {ctrl_irq_en, ctrl_en};
         end
         2'd1: begin
            rd_mux[23:0] = period;
         end
         2'd2: begin
            rd_mux[DATA_W-1:0] = stable;
            rd_mux[8]          = chg;
         end
         default: begin
            rd_mux[3:0] = debounce;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s_readdata <= 32'd0;
         irq        <= 1'b0;
      end else begin
         s_readdata <= s_read ? rd_mux : 32'd0;
         irq        <= chg & ctrl_irq_en;
      end
   end

endmodule

// File: tb/tb_blinky_binary_poller.sv
// Self-checking bench: PIO slave with stall control plus a debounce model
// driven by the values the slave actually returned.
module tb_blinky_binary_poller;

   localparam int DATA_W = 2;
   localparam int DEF_P  = 50000;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  s_address = 2'd0;
   logic        s_read = 1'b0;
   logic        s_write = 1'b0;
   logic [31:0] s_writedata = 32'd0;
   logic [31:0] s_readdata;
   logic [1:0]  m_address;
   logic        m_read;
   logic        m_waitrequest = 1'b0;
   logic [31:0] m_readdata = 32'd0;
   logic        irq;

   int n_checks = 0;
   int n_fail   = 0;

   logic [1:0] pio_value = 2'b00;
   int         stall_left = 0;
   int         acc_count = 0;
   int         cycle = 0;
   int         acc_cycle[$];
   int         req_cycles = 0;
   int         run_len = 0;
   int         runs[$];
   logic       acc_now;
   logic [1:0] acc_val;
   logic [31:0] rd_word;

   logic [1:0] ref_stable = 2'b00;
   logic [1:0] ref_last = 2'b00;
   int         ref_run = 0;
   bit         ref_seen = 0;
   logic       ref_chg = 1'b0;
   int         ref_deb = 1;

   blinky_binary_poller #(.DATA_W(DATA_W), .DEFAULT_PERIOD(DEF_P)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .s_address     (s_address),
      .s_read        (s_read),
      .s_write       (s_write),
      .s_writedata   (s_writedata),
      .s_readdata    (s_readdata),
      .m_address     (m_address),
      .m_read        (m_read),
      .m_waitrequest (m_waitrequest),
      .m_readdata    (m_readdata),
      .irq           (irq)
   );

   always #5 clk = ~clk;

   // Debounced value = last sample once the trailing run of equal samples is long enough.
   task automatic model_sample(input logic [1:0] v);
      int need;
      if (ref_seen && v == ref_last) ref_run = (ref_run < 15) ? ref_run + 1 : 15;
      else ref_run = 1;
      ref_seen = 1;
      ref_last = v;
      need = (ref_deb < 1) ? 1 : ref_deb;
      if (ref_run >= need && v != ref_stable) begin
         ref_stable = v;
         ref_chg    = 1'b1;
      end
   endtask

   task automatic model_clear();
      ref_stable = 2'b00;
      ref_last   = 2'b00;
      ref_run    = 0;
      ref_seen   = 0;
      ref_chg    = 1'b0;
      ref_deb    = 1;
   endtask

   // PIO slave: read data valid only in the cycle after acceptance, garbage otherwise.
   always @(posedge clk) begin
      cycle   = cycle + 1;
      acc_now = (m_read === 1'b1) && (m_waitrequest === 1'b0);
      acc_val = pio_value;
      if (acc_now) begin
         acc_count = acc_count + 1;
         acc_cycle.push_back(cycle);
         model_sample(acc_val);
      end
      #1;
      rd_word = $urandom();
      rd_word[1:0] = acc_now ? acc_val : ~acc_val;
      m_readdata = rd_word;
   end

   always @(negedge clk) begin
      if (m_read === 1'b1 && stall_left > 0) begin
         m_waitrequest = 1'b1;
         stall_left = stall_left - 1;
      end else begin
         m_waitrequest = 1'b0;
      end
   end

   always @(negedge clk) begin
      if (m_read === 1'b1) begin
         run_len = run_len + 1;
         req_cycles = req_cycles + 1;
      end else if (run_len > 0) begin
         runs.push_back(run_len);
         run_len = 0;
      end
   end

   task automatic do_reset();
      reset_n = 1'b0;
      s_read = 1'b0; s_write = 1'b0; s_address = 2'd0; s_writedata = 32'd0;
      stall_left = 0;
      pio_value = 2'b00;
      model_clear();
      repeat (3) @(negedge clk);
      acc_count = 0;
      acc_cycle.delete();
      runs.delete();
      run_len = 0;
      req_cycles = 0;
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
      s_address = a; s_writedata = d; s_write = 1'b1;
      @(negedge clk);
      s_write = 1'b0;
   endtask

   task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
      s_address = a; s_read = 1'b1;
      @(negedge clk);
      s_read = 1'b0;
      d = s_readdata;
   endtask

   task automatic wait_acc(input int target, input int budget, input string name);
      int n = 0;
      while (acc_count < target && n < budget) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (acc_count < target) begin
         n_fail++;
         $display("[TB] FAIL %s: accepted reads %0d, required %0d within %0d cycles", name, acc_count, target, budget);
      end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      do_reset();
      n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_m_read: got %b want 0", m_read); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_irq: got %b want 0", irq); end
      n_checks++; if (m_address !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_m_address: got %0d want 0", m_address); end
      n_checks++; if (s_readdata !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_readdata: got %h want 0", s_readdata); end
      csr_read(2'd0, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_ctrl: got %h want 0", d); end
      csr_read(2'd1, d);
      n_checks++; if (d !== 32'(DEF_P)) begin n_fail++; $display("[TB] FAIL reset_period: got %0d want %0d", d, DEF_P); end
      csr_read(2'd2, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_status: got %h want 0", d); end
      csr_read(2'd3, d);
      n_checks++; if (d !== 32'd1) begin n_fail++; $display("[TB] FAIL reset_debounce: got %h want 1", d); end
   endtask

   task automatic test_basic_poll();
      logic [31:0] d;
      do_reset();
      pio_value = 2'b10;
      csr_write(2'd1, 32'd4);
      csr_write(2'd3, 32'd1);
      csr_write(2'd0, 32'd1);
      wait_acc(4, 100, "basic_polls");
      for (int i = 1; i < 4; i++) begin
         n_checks++;
         if (acc_cycle[i] - acc_cycle[i-1] != 7) begin
            n_fail++; $display("[TB] FAIL basic_spacing%0d: got %0d want 7", i, acc_cycle[i] - acc_cycle[i-1]);
         end
      end
      repeat (2) @(negedge clk);
      csr_read(2'd2, d);
      n_checks++; if (d !== 32'h102) begin n_fail++; $display("[TB] FAIL basic_status: got %h want 102", d); end
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL basic_irq_disabled: got %b want 0", irq); end
      n_checks++; if (runs.size() < 1 || runs[0] != 1) begin n_fail++; $display("[TB] FAIL basic_pulse_len: got %0d want 1", runs.size() ? runs[0] : -1); end
   endtask

   task automatic test_debounce();
      logic [31:0] d;
      logic [1:0]  scr [8] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11, 2'b11};
      logic [31:0] exp_st [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h103, 32'h003};
      do_reset();
      ref_deb = 3;
      pio_value = scr[0];
      csr_write(2'd1, 32'd10);
      csr_write(2'd3, 32'd3);
      csr_write(2'd0, 32'd1);
      for (int i = 0; i < 8; i++) begin
         wait_acc(i + 1, 60, "debounce_poll");
         if (i < 7) pio_value = scr[i+1];
         repeat (2) @(negedge clk);
         csr_read(2'd2, d);
         n_checks++;
         if (d !== exp_st[i]) begin n_fail++; $display("[TB] FAIL debounce_status%0d: got %h want %h", i, d, exp_st[i]); end
         if (i == 6) begin
            csr_write(2'd2, 32'h100);
            ref_chg = 1'b0;
         end
      end
   endtask

   task automatic test_stall();
      logic [31:0] d;
      do_reset();
      pio_value = 2'b01;
      stall_left = 5;
      csr_write(2'd1, 32'd3);
      csr_write(2'd0, 32'd1);
      wait_acc(1, 60, "stall_accept");
      repeat (2) @(negedge clk);
      csr_read(2'd2, d);
      n_checks++; if (runs.size() < 1 || runs[0] != 6) begin n_fail++; $display("[TB] FAIL stall_read_len: got %0d want 6", runs.size() ? runs[0] : -1); end
      n_checks++; if (acc_count != 1 || runs.size() != 1) begin n_fail++; $display("[TB] FAIL stall_single_req: got %0d accepts %0d requests want 1 1", acc_count, runs.size()); end
      n_checks++; if (d !== 32'h101) begin n_fail++; $display("[TB] FAIL stall_capture: got %h want 101", d); end
   endtask

   task automatic test_irq();
      logic [31:0] d;
      do_reset();
      pio_value = 2'b10;
      csr_write(2'd1, 32'd10);
      csr_write(2'd0, 32'd3);
      wait_acc(1, 60, "irq_first_poll");
      repeat (3) @(negedge clk);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_set: got %b want 1", irq); end
      csr_write(2'd2, 32'h100);
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_clear_lat1: got %b want 1", irq); end
      @(negedge clk);
      n_checks++; if (irq !== 1'b0) begin n_fail++; $display("[TB] FAIL irq_clear_lat2: got %b want 0", irq); end
      pio_value = 2'b01;
      wait_acc(2, 60, "irq_second_poll");
      @(negedge clk);
      csr_write(2'd2, 32'h100);
      csr_read(2'd2, d);
      n_checks++; if (d !== 32'h101) begin n_fail++; $display("[TB] FAIL irq_set_wins: got %h want 101", d); end
      n_checks++; if (irq !== 1'b1) begin n_fail++; $display("[TB] FAIL irq_after_set_wins: got %b want 1", irq); end
   endtask

   task automatic test_period();
      logic [31:0] d;
      int base, rc, ac;
      do_reset();
      pio_value = 2'b11;
      csr_write(2'd1, 32'd0);
      csr_write(2'd0, 32'd1);
      wait_acc(4, 60, "period0_polls");
      for (int i = 1; i < 4; i++) begin
         n_checks++;
         if (acc_cycle[i] - acc_cycle[i-1] != 4) begin
            n_fail++; $display("[TB] FAIL period0_spacing%0d: got %0d want 4", i, acc_cycle[i] - acc_cycle[i-1]);
         end
      end
      csr_write(2'd1, 32'd12);
      base = acc_count;
      wait_acc(base + 2, 100, "period12_polls");
      repeat (3) @(negedge clk);
      csr_write(2'd1, 32'd5);
      wait_acc(base + 4, 100, "period5_polls");
      n_checks++;
      if (acc_cycle[base+2] - acc_cycle[base+1] != 15) begin
         n_fail++; $display("[TB] FAIL period_write_in_wait: got %0d want 15", acc_cycle[base+2] - acc_cycle[base+1]);
      end
      n_checks++;
      if (acc_cycle[base+3] - acc_cycle[base+2] != 8) begin
         n_fail++; $display("[TB] FAIL period_next_reload: got %0d want 8", acc_cycle[base+3] - acc_cycle[base+2]);
      end
      wait_acc(base + 5, 60, "disable_sync");
      repeat (3) @(negedge clk);
      csr_write(2'd0, 32'd0);
      rc = req_cycles;
      ac = acc_count;
      repeat (40) @(negedge clk);
      n_checks++; if (req_cycles != rc || acc_count != ac) begin n_fail++; $display("[TB] FAIL disable_in_wait: got %0d extra request cycles want 0", req_cycles - rc); end
      csr_read(2'd0, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("[TB] FAIL disable_ctrl: got %h want 0", d); end
   endtask

   task automatic test_reset_mid_request();
      logic [31:0] d;
      int n = 0;
      do_reset();
      pio_value = 2'b11;
      stall_left = 1000;
      csr_write(2'd1, 32'd2);
      csr_write(2'd0, 32'd3);
      while (m_read !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      n_checks++; if (m_read !== 1'b1) begin n_fail++; $display("[TB] FAIL rstreq_enter_req: got %b want 1", m_read); end
      repeat (2) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      n_checks++; if (m_read !== 1'b0) begin n_fail++; $display("[TB] FAIL rstreq_async_drop: got %b want 0", m_read); end
      n_checks++; if (irq !== 1'b0 || s_readdata !== 32'd0) begin n_fail++; $display("[TB] FAIL rstreq_outputs: got irq %b rd %h want 0 0", irq, s_readdata); end
      stall_left = 0;
      model_clear();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      csr_read(2'd0, d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("[TB] FAIL rstreq_ctrl: got %h want 0", d); end
      csr_read(2'd1, d);
      n_checks++; if (d !== 32'(DEF_P)) begin n_fail++; $display("[TB] FAIL rstreq_period: got %0d want %0d", d, DEF_P); end
      csr_read(2'd3, d);
      n_checks++; if (d !== 32'd1) begin n_fail++; $display("[TB] FAIL rstreq_debounce: got %h want 1", d); end
      repeat (30) @(negedge clk);
      csr_read(2'd2, d);
      n_checks++; if (d !== 32'd0 || acc_count != 0) begin n_fail++; $display("[TB] FAIL rstreq_no_chg: got status %h accepts %0d want 0 0", d, acc_count); end
   endtask

   task automatic test_random_debounce();
      logic [31:0] d, want;
      int   deb, per;
      logic irq_en;
      do_reset();
      deb = $urandom_range(1, 4);
      per = $urandom_range(10, 16);
      irq_en = 1'($urandom_range(0, 1));
      ref_deb = deb;
      pio_value = 2'($urandom());
      csr_write(2'd1, 32'(per));
      csr_write(2'd3, 32'(deb));
      csr_write(2'd0, {30'd0, irq_en, 1'b1});
      for (int i = 0; i < 24; i++) begin
         wait_acc(i + 1, 80, "random_poll");
         if ($urandom_range(0, 2) == 0) pio_value = 2'($urandom());
         repeat (2) @(negedge clk);
         csr_read(2'd2, d);
         want = {23'd0, ref_chg, 6'd0, ref_stable};
         n_checks++;
         if (d !== want) begin n_fail++; $display("[TB] FAIL random_status%0d: got %h want %h (deb %0d)", i, d, want, deb); end
         n_checks++;
         if (irq !== (ref_chg & irq_en)) begin n_fail++; $display("[TB] FAIL random_irq%0d: got %b want %b", i, irq, ref_chg & irq_en); end
         if ($urandom_range(0, 3) == 0) begin
            csr_write(2'd2, 32'h100);
            ref_chg = 1'b0;
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic_poll();
      test_debounce();
      test_stall();
      test_irq();
      test_period();
      test_reset_mid_request();
      test_random_debounce();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/blinky_binary_poller.md
BLINKY_BINARY_POLLER -- requirements
Module: blinky_binary_poller

Interface
REQ-001 The block SHALL have parameter DATA_W, default 2, width of the polled input field taken from m_readdata[DATA_W-1:0].
REQ-002 The block SHALL have parameter DEFAULT_PERIOD, default 50000, reset value of the PERIOD register.
REQ-003 One clock; reset is asynchronous and active-low: clk, reset_n.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 s_address  input  2  config slave word address.
REQ-007 s_read  input  1  config slave read strobe.
REQ-008 s_write  input  1  config slave write strobe.
REQ-009 s_writedata  input  32  config slave write data.
REQ-010 s_readdata  output  32  config slave read data, registered, read latency 1.
REQ-011 m_address  output  2  master address to PIO slave; always 0.
REQ-012 m_read  output  1  master read request.
REQ-013 m_waitrequest  input  1  PIO stall; request accepted on cycle with m_read=1 and m_waitrequest=0.
REQ-014 m_readdata  input  32  PIO read data, valid exactly 1 cycle after acceptance.
REQ-015 irq  output  1  level interrupt: change flag AND irq enable.

Function
REQ-016 Register map SHALL be: 0 CTRL {bit0 EN, bit1 IRQ_EN}; 1 PERIOD [23:0]; 2 STATUS {[DATA_W-1:0] STABLE, bit8 CHG}; 3 DEBOUNCE [3:0]; unused bits read 0.
REQ-017 Writes SHALL take effect the cycle after s_write; writing 1 to STATUS bit8 SHALL clear CHG; other STATUS bits read-only.
REQ-018 s_readdata SHALL update every cycle with selected register when s_read=1, else 0.
REQ-019 FSM states SHALL be IDLE, WAIT, REQ, CAPT, EVAL.
REQ-020 IDLE: m_read=0; go WAIT when EN=1, loading interval counter with max(PERIOD,1)-1.
REQ-021 WAIT: decrement counter each cycle; at 0 go REQ; EN=0 returns to IDLE next cycle.
REQ-022 REQ: hold m_read=1, m_address=0 until m_waitrequest=0; then CAPT; EN cleared in REQ SHALL NOT abort an outstanding request.
REQ-023 CAPT: sample m_readdata[DATA_W-1:0] into SAMPLE; go EVAL.
REQ-024 EVAL: if SAMPLE==previous sample, increment match count (saturating at 15) else reset it to 1; when match count reaches max(DEBOUNCE,1) and SAMPLE!=STABLE, update STABLE and set CHG; then WAIT (EN=1) or IDLE (EN=0), reloading interval counter.
REQ-025 Poll spacing SHALL be exactly max(PERIOD,1)+3 cycles when m_waitrequest=0 (WAIT count + REQ + CAPT + EVAL).
REQ-026 CHG set by EVAL and cleared by software write in the same cycle: set SHALL win.
REQ-027 PERIOD written during WAIT SHALL apply from the next reload only.
REQ-028 irq SHALL be registered: irq = CHG & IRQ_EN, one cycle after either changes.

Reset
REQ-029 On reset_n=0: FSM=IDLE, CTRL=0, PERIOD=DEFAULT_PERIOD, DEBOUNCE=1, STABLE=0, CHG=0, SAMPLE=0, match count=0, counter=0, m_read=0, s_readdata=0, irq=0.
REQ-030 Reset asserted mid-request SHALL drop m_read immediately; the pending read data is discarded.

Verification
REQ-031 PERIOD=4, DEBOUNCE=1, EN=1, input 2'b10, no stall -> m_read pulses every 7 cycles; STABLE=2'b10, CHG=1 after first poll; irq=0 (IRQ_EN=0).
REQ-032 DEBOUNCE=3, input toggles 01/10 each poll then holds 11 -> STABLE changes to 11 only after third consecutive 11 sample; CHG set once.
REQ-033 m_waitrequest held high 5 cycles in REQ -> m_read stays 1 for 6 cycles, data captured the cycle after acceptance, no duplicate request.
REQ-034 IRQ_EN=1, CHG=1 -> irq=1; write STATUS bit8=1 -> irq=0 two cycles later; write coinciding with new change -> CHG remains 1.
REQ-035 PERIOD=0 -> treated as 1, poll spacing 4 cycles; EN cleared during WAIT -> IDLE next cycle, m_read never asserted.
REQ-036 reset_n pulsed low during REQ -> m_read=0 asynchronously, all registers at REQ-029 values, no CHG set.
